// File: rtl/uart_tx_controller_pkg.sv
// UartGlobalPkg: shared UART configuration types, transmit FSM states and divisor/parity helpers.
package UartGlobalPkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [4:0] {
        OVERSAMPLING_8  = 5'd8,
        OVERSAMPLING_16 = 5'd16
    } overSamplingEnum;

    typedef enum logic [16:0] {
        BAUD_4800   = 17'd4800,
        BAUD_9600   = 17'd9600,
        BAUD_19200  = 17'd19200,
        BAUD_38400  = 17'd38400,
        BAUD_57600  = 17'd57600,
        BAUD_115200 = 17'd115200
    } baudRateEnum;

    typedef enum logic [3:0] {
        FIVE_BIT  = 4'd5,
        SIX_BIT   = 4'd6,
        SEVEN_BIT = 4'd7,
        EIGHT_BIT = 4'd8
    } dataTypeEnum;

    typedef enum logic {
        EVEN_PARITY = 1'b0,
        ODD_PARITY  = 1'b1
    } parityTypeEnum;

    typedef enum logic [1:0] {
        ONE_BIT = 2'd1,
        TWO_BIT = 2'd2
    } stopBitEnum;

    typedef struct packed {
        overSamplingEnum uartOverSamplingMethod;
        baudRateEnum     uartBaudRate;
        dataTypeEnum     uartDataType;
        parityTypeEnum   uartParityType;
        logic            uartParityEnable;
        logic            uartParityErrorInjection;
    } UartConfigStruct;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uartTxStateEnum;

    localparam UartConfigStruct CFG_RESET = '{OVERSAMPLING_16, BAUD_9600, EIGHT_BIT, EVEN_PARITY, 1'b0, 1'b0};

    // floor(floor(clk/baud)/os) == floor(clk/(baud*os)); each branch folds to a constant
    function automatic logic [31:0] baud_divisor(input int unsigned clk_hz, input baudRateEnum baud,
                                                 input overSamplingEnum os);
        logic [31:0] per_baud;
        case (baud)
            BAUD_4800:   per_baud = clk_hz / 32'd4800;
            BAUD_19200:  per_baud = clk_hz / 32'd19200;
            BAUD_38400:  per_baud = clk_hz / 32'd38400;
            BAUD_57600:  per_baud = clk_hz / 32'd57600;
            BAUD_115200: per_baud = clk_hz / 32'd115200;
            default:     per_baud = clk_hz / 32'd9600;
        endcase
        return (os == OVERSAMPLING_16) ? per_baud >> 4 : per_baud >> 3;
    endfunction

    function automatic logic data_parity(input logic [DATA_WIDTH-1:0] d, input dataTypeEnum w);
        return ^(d & ({DATA_WIDTH{1'b1}} >> (4'(DATA_WIDTH) - w)));
    endfunction

endpackage

// File: rtl/uart_tx_controller_if.sv
// uart_tx_controller_if: valid/ready byte handshake between the packet source and the transmitter.
interface uart_tx_controller_if;
    import UartGlobalPkg::*;

    logic [DATA_WIDTH-1:0] txData;
    logic                  txValid;
    logic                  txReady;

    modport master (output txData, output txValid, input txReady);
    modport slave  (input txData, input txValid, output txReady);

endinterface

// File: rtl/uart_tx_controller_baud_tick_gen.sv
// uart_baud_tick_gen: free-running divisor counter emitting a one-cycle oversample tick while enabled.
module uart_baud_tick_gen #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == divisor - DIV_W'(1));
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + DIV_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: sends one frame at a time (start, data LSB first, optional parity, stop)
// on tx, latching data and configuration at the accept handshake.
module uart_tx_controller
    import UartGlobalPkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  UartConfigStruct            uartConfig,
    input  stopBitEnum                 stopBits,
    uart_tx_controller_if.slave        tx_if,
    output logic                       tx,
    output logic                       busy,
    output logic                       frameDone,
    output logic                       sampleTick
);

    uartTxStateEnum        state_q, state_d;
    UartConfigStruct       cfg_q, cfg_d;
    stopBitEnum            stop_q, stop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            idx_q, idx_d;
    logic [4:0]            os_cnt_q, os_cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic [31:0]           div_raw, divisor;
    logic                  ready, accept, bit_done, last_data, last_stop, par_bit;

    always_comb begin
        div_raw   = baud_divisor(CLK_FREQ_HZ, cfg_q.uartBaudRate, cfg_q.uartOverSamplingMethod);
        divisor   = (div_raw == '0) ? 32'd1 : div_raw;
        ready     = (state_q == IDLE);
        accept    = tx_if.txValid && ready;
        bit_done  = sampleTick && (os_cnt_q == cfg_q.uartOverSamplingMethod - 5'd1);
        last_data = (idx_q == 3'(cfg_q.uartDataType - 4'd1));
        last_stop = (idx_q == {1'b0, stop_q - 2'd1});
        par_bit   = data_parity(data_q, cfg_q.uartDataType) ^ (cfg_q.uartParityType == ODD_PARITY)
                    ^ cfg_q.uartParityErrorInjection;
    end

    assign tx_if.txReady = ready;

    uart_baud_tick_gen #(.DIV_W(32)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (busy),
        .divisor(divisor),
        .tick   (sampleTick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cfg_q    <= CFG_RESET;
            stop_q   <= ONE_BIT;
            data_q   <= '0;
            idx_q    <= '0;
            os_cnt_q <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            os_cnt_q <= os_cnt_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    // idx_q counts data bits, then is reused to count stop bits
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cfg_d    = accept ? uartConfig : cfg_q;
        stop_d   = accept ? stopBits : stop_q;
        data_d   = accept ? tx_if.txData : data_q;
        os_cnt_d = (accept || bit_done) ? '0 : sampleTick ? os_cnt_q + 5'd1 : os_cnt_q;
        case (state_q)
            IDLE: begin
                state_d = accept ? START : IDLE;
                idx_d   = '0;
            end
            START:  state_d = bit_done ? DATA : START;
            DATA: begin
                if (bit_done) begin
                    state_d = last_data ? (cfg_q.uartParityEnable ? PARITY : STOP) : DATA;
                    idx_d   = last_data ? '0 : idx_q + 3'd1;
                end
            end
            PARITY: state_d = bit_done ? STOP : PARITY;
            STOP: begin
                if (bit_done) begin
                    state_d = last_stop ? IDLE : STOP;
                    idx_d   = last_stop ? '0 : idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        tx_d   = (state_d == DATA) ? data_q[idx_d] : (state_d == PARITY) ? par_bit : (state_d != START);
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    assign tx        = tx_q;
    assign frameDone = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed frames against hand-computed tx bit sequences, plus a
// second instance whose divisor clamps to 1.
module tb_uart_tx_controller;
    import UartGlobalPkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    uart_tx_controller_if m_if ();
    uart_tx_controller_if c_if ();

    UartConfigStruct m_cfg, c_cfg;
    stopBitEnum      m_stop, c_stop;
    logic            m_tx, m_busy, m_done, m_tick;
    logic            c_tx, c_busy, c_done, c_tick;

    uart_tx_controller #(.CLK_FREQ_HZ(1_228_800)) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .uartConfig(m_cfg),
        .stopBits  (m_stop),
        .tx_if     (m_if),
        .tx        (m_tx),
        .busy      (m_busy),
        .frameDone (m_done),
        .sampleTick(m_tick)
    );

    uart_tx_controller #(.CLK_FREQ_HZ(100_000)) u_clamp (
        .clk       (clk),
        .reset     (rst_n),
        .uartConfig(c_cfg),
        .stopBits  (c_stop),
        .tx_if     (c_if),
        .tx        (c_tx),
        .busy      (c_busy),
        .frameDone (c_done),
        .sampleTick(c_tick)
    );

    function automatic UartConfigStruct mk(input baudRateEnum b, input dataTypeEnum d,
                                           input parityTypeEnum p, input logic pe, input logic inj);
        UartConfigStruct c;
        c.uartOverSamplingMethod   = OVERSAMPLING_16;
        c.uartBaudRate             = b;
        c.uartDataType             = d;
        c.uartParityType           = p;
        c.uartParityEnable         = pe;
        c.uartParityErrorInjection = inj;
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d);
        if (sel) begin c_if.txData = d; c_if.txValid = 1'b1; end
        else     begin m_if.txData = d; m_if.txValid = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        if (sel) c_if.txValid = 1'b0;
        else     m_if.txValid = 1'b0;
    endtask

    // called on the first negedge after the accept edge; returns on the frameDone cycle
    task automatic frame(input bit sel, input logic [15:0] exp, input int nbits, input int per, input string tag);
        logic t, f, l;
        int   ticks;
        ticks = 0;
        f = 1'b0;
        l = 1'b0;
        check({tag, "_busy"}, 16'(sel ? {c_busy, c_if.txReady} : {m_busy, m_if.txReady}), 16'b10);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < per; c++) begin
                t = sel ? c_tx : m_tx;
                if (c == 0) f = t;
                if (c == per - 1) l = t;
                ticks += int'(sel ? c_tick : m_tick);
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, b), 16'({f, l}), 16'({2{exp[b]}}));
        end
        check({tag, "_ticks"}, 16'(ticks), 16'(nbits * 16));
        check({tag, "_done"}, 16'(sel ? {c_done, c_if.txReady, c_tx} : {m_done, m_if.txReady, m_tx}), 16'b111);
    endtask

    initial begin
        int stray;
        m_if.txValid = 1'b0;
        m_if.txData  = '0;
        c_if.txValid = 1'b0;
        c_if.txData  = '0;
        m_cfg  = mk(BAUD_9600, EIGHT_BIT, EVEN_PARITY, 1'b0, 1'b0);
        c_cfg  = mk(BAUD_19200, EIGHT_BIT, EVEN_PARITY, 1'b0, 1'b0);
        m_stop = ONE_BIT;
        c_stop = ONE_BIT;
        repeat (3) @(negedge clk);
        check("reset_m", 16'({m_tx, m_busy, m_if.txReady, m_done, m_tick}), 16'b10100);
        check("reset_c", 16'({c_tx, c_busy, c_if.txReady, c_done, c_tick}), 16'b10100);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 8'hA5);
        frame(1'b0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 128, "8n1");
        @(negedge clk);
        check("8n1_after", 16'({m_done, m_busy, m_tx}), 16'b001);

        m_cfg  = mk(BAUD_9600, SEVEN_BIT, EVEN_PARITY, 1'b1, 1'b0);
        m_stop = TWO_BIT;
        send(1'b0, 8'h53);
        frame(1'b0, {5'b0, 2'b11, 1'b0, 7'h53, 1'b0}, 11, 128, "7e2");
        @(negedge clk);
        m_cfg.uartParityType = ODD_PARITY;
        send(1'b0, 8'h53);
        frame(1'b0, {5'b0, 2'b11, 1'b1, 7'h53, 1'b0}, 11, 128, "7o2");
        @(negedge clk);

        m_cfg  = mk(BAUD_9600, FIVE_BIT, EVEN_PARITY, 1'b1, 1'b1);
        m_stop = ONE_BIT;
        send(1'b0, 8'h1F);
        frame(1'b0, {8'b0, 1'b1, 1'b0, 5'h1F, 1'b0}, 8, 128, "5e1_inj");
        @(negedge clk);
        m_cfg = mk(BAUD_9600, FIVE_BIT, EVEN_PARITY, 1'b1, 1'b0);
        send(1'b0, 8'hE1);
        frame(1'b0, {8'b0, 1'b1, 1'b1, 5'h01, 1'b0}, 8, 128, "5e1_mask");
        @(negedge clk);

        m_cfg        = mk(BAUD_9600, EIGHT_BIT, EVEN_PARITY, 1'b0, 1'b0);
        m_if.txData  = 8'h01;
        m_if.txValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_if.txData = 8'h02;
        m_cfg       = mk(BAUD_9600, SEVEN_BIT, EVEN_PARITY, 1'b1, 1'b0);
        frame(1'b0, {6'b0, 1'b1, 8'h01, 1'b0}, 10, 128, "b2b_first");
        @(negedge clk);
        m_if.txValid = 1'b0;
        frame(1'b0, {6'b0, 1'b1, 1'b1, 7'h02, 1'b0}, 10, 128, "b2b_second");
        @(negedge clk);

        m_cfg = mk(BAUD_9600, EIGHT_BIT, EVEN_PARITY, 1'b0, 1'b0);
        send(1'b0, 8'hA5);
        repeat (4 * 128 + 64) @(negedge clk);
        check("pre_reset", 16'({m_busy, m_tx}), 16'b10);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 16'({m_tx, m_busy, m_if.txReady}), 16'b101);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (1000) begin
            stray += int'(m_done) + int'(!m_tx);
            @(negedge clk);
        end
        check("reset_no_done", 16'(stray), 16'd0);
        send(1'b0, 8'h3C);
        frame(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 128, "after_reset");
        @(negedge clk);

        send(1'b1, 8'h96);
        frame(1'b1, {6'b0, 1'b1, 8'h96, 1'b0}, 10, 16, "clamp");
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_controller.md
# uart_tx_controller

Sequences one UART transmit frame at a time: latches a data byte plus the active configuration, generates the oversampled baud tick, and drives the serial line through start, data, optional parity and stop bits. It sits between the transmit packet source and the `tx` pin. It is the transmit-side controller for the `UartConfigStruct` / `stopBitEnum` settings defined in `UartGlobalPkg`.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency used for divisor computation.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `uartConfig`  in  `UartConfigStruct`: oversampling, baud, data width, parity type/enable, parity-error injection.
- `stopBits`  in  `stopBitEnum`: ONE_BIT or TWO_BIT.
- `txData`  in  `DATA_WIDTH`: byte to send; only the low `uartDataType` bits are used.
- `txValid`  in  1: source offers `txData`.
- `txReady`  out  1: controller can accept; reset 1.
- `tx`  out  1: serial line, idle high; reset 1.
- `busy`  out  1: frame in progress; reset 0.
- `frameDone`  out  1: one-cycle pulse at frame end; reset 0.
- `sampleTick`  out  1: one-cycle oversample tick, free-running while busy; reset 0.

## Operation
- Divisor = CLK_FREQ_HZ / (uartBaudRate × uartOverSamplingMethod), truncated; a result of 0 is clamped to 1.
- Bit period = divisor × oversampling cycles, exact, with no cumulative drift.
- Handshake: accept when `txValid && txReady`. `txReady` = 1 only in IDLE. At acceptance, `txData`, `uartConfig` and `stopBits` are latched. Later input changes have no effect on the current frame.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: `tx` = 1. On accept, go to START.
  - START: `tx` = 0 for one bit period, then go to DATA.
  - DATA: send bits LSB first, bits 0..W-1, where W = latched `uartDataType` (5–8). After bit W-1, go to PARITY if `uartParityEnable`, else go to STOP.
  - PARITY: even parity = XOR of the W data bits; odd parity = inverse of that. If `uartParityErrorInjection`, the bit is inverted.
  - STOP: `tx` = 1 for `stopBits` bit periods, then go to IDLE.
- `busy` = 1 in every state except IDLE.
- `frameDone` = 1 in the first IDLE cycle after STOP completes.
- Tick and bit counters clear at acceptance, so the start bit is full length.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronous), FSM goes to IDLE, counters clear, and the frame is dropped with no `frameDone`.

## Timing
- Accept at edge N → `tx` falls at edge N+1 (registered output). `busy` rises at N+1 and `txReady` falls at N+1.
- Each bit lasts exactly divisor × oversampling cycles.
- Frame length = (1 + W + P + S) bit periods, where P = 1 if parity is enabled and S = `stopBits`.
- The final STOP cycle is followed by one IDLE cycle with `frameDone` = 1 and `txReady` = 1.
- If `txValid` = 1 in that IDLE cycle, the next start bit begins the following cycle. Minimum inter-frame idle = stop period + 1 cycle.
- `sampleTick` pulses every `divisor` cycles while busy, first pulse `divisor` cycles after acceptance.
- `txValid` while not ready is ignored; nothing is queued.

## Structure
- Reuse `UartGlobalPkg` for `UartConfigStruct`, `stopBitEnum`, `dataTypeEnum` and `DATA_WIDTH`.
- Add `uartTxStateEnum` {IDLE, START, DATA, PARITY, STOP} to `UartGlobalPkg`.
- One sub-module, `uart_baud_tick_gen`: a divisor counter with a synchronous clear, emitting `sampleTick`. The bit-period counter (0..oversampling-1) and the FSM stay in `uart_tx_controller`.

## Test plan
Default settings for all scenarios: CLK_FREQ_HZ = 1_228_800 with BAUD_9600 and OVERSAMPLING_16, giving divisor 8 and a 128-cycle bit period.

- **Basic 8N1 frame:** send 0xA5, EIGHT_BIT, parity off, ONE_BIT stop. Expected `tx` sequence, 128 cycles each: 0, 1,0,1,0,0,1,0,1, 1. Total 1280 cycles, then `frameDone` pulses.
- **7E2 with odd/even parity:** send 0x53, SEVEN_BIT, EVEN_PARITY, TWO_BIT stop. Expected: data 1,1,0,0,1,0,1, parity 0, two stop bits. Repeat with ODD_PARITY: parity bit = 1.
- **Parity-error injection and narrow data:** send 0x1F, FIVE_BIT, EVEN_PARITY, injection on. Expected: data 1,1,1,1,1, parity bit = 0 instead of 1. Upper bits of `txData` are never driven.
- **Back-to-back with mid-frame config change:** hold `txValid` = 1 for 0x01 then 0x02. Expected: second start bit begins exactly 1 cycle after the `frameDone` cycle. Changing `uartConfig` mid-frame has no effect until the next accept.
- **Reset mid-frame:** assert `reset` during DATA bit 3. Expected: `tx` = 1 asynchronously, `busy` = 0, `txReady` = 1, no `frameDone`. The next accepted frame is a full, correct frame.
- **Divisor clamp:** CLK_FREQ_HZ = 100_000 with BAUD_19200 and OVERSAMPLING_16 gives divisor 0, clamped to 1. Expected: bit period = 16 cycles and `sampleTick` high every cycle while busy.
